mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped serial transmitter that sits on the VeriRISC memory bus as a responder, alongside `memory`. The CPU's `controller` and `tri_state_buffer` act as the bus initiator. This block decodes two addresses at the top of the 5-bit address space, accepts bytes on CPU stores into a small FIFO, and returns status on CPU loads. It serialises queued bytes onto a UART-style `tx` line: 8N1, LSB first. The top level uses `io_sel` to gate `memory` `rd`/`wr` off for the mapped addresses.

## Interface
- `AWIDTH`, 5, address width; matches the CPU address bus.
- `DWIDTH`, 8, data width; fixed at 8; the frame is always 8 data bits.
- `TXDATA_ADDR`, 5'h1E, address for the byte write port and the FIFO-count read.
- `STATUS_ADDR`, 5'h1F, address for status read and overflow clear.
- `FIFO_DEPTH`, 4, number of FIFO entries; must be a power of 2, ≥2.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd`  in  1  bus read strobe from controller.
- `wr`  in  1  bus write strobe from controller.
- `addr`  in  AWIDTH  bus address.
- `data`  inout  DWIDTH  shared bidirectional data bus.
- `io_sel`  out  1  combinational; 1 when `addr` == `TXDATA_ADDR` or `STATUS_ADDR`.
- `tx`  out  1  serial output; idle high.
- `tx_busy`  out  1  1 whenever the serialiser is not in IDLE.

## Operation
- **Bus drive**
  - `data` is driven only when `rd && io_sel`; otherwise it is high-Z.
  - The read path is combinational, matching `memory` read timing.
- **Read of `TXDATA_ADDR`:** returns the FIFO occupancy count, zero-extended to 8 bits.
- **Read of `STATUS_ADDR`:** returns {4'b0, overflow, tx_busy, full, empty}.
- **Write to `TXDATA_ADDR`** (`wr` high at the clock edge)
  - If `!full` (as sampled before the edge), `data` is pushed.
  - If full, the byte is dropped and the sticky `overflow` flag is set.
  - A pop at the same edge does not rescue a write to a full FIFO.
- **Write to `STATUS_ADDR`:** `data[3]`=1 clears `overflow`. All other bits are ignored.
- **Unmapped addresses:** `rd`/`wr` have no effect and `io_sel`=0.
- **`rd` and `wr` high in the same cycle:** the write takes effect, and the read bus is still driven.
- **FIFO**
  - Circular buffer with wrapping read and write pointers plus a count register.
  - Push and pop at the same edge when not full and not empty: count unchanged, both pointers advance.
- **Serialiser FSM**
  - IDLE: `tx`=1. If `!empty`, pop the head into the shift register, clear the bit timer, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, shift right after each bit; after bit 7 go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Counters**
  - The bit timer counts 0..`CLKS_PER_BIT`-1 and wraps.
  - The bit index counts 0..7.
  - Widths are $clog2 of the respective ranges.

## Timing
- **Reset values**
  - FIFO empty, both pointers 0, count 0.
  - `overflow`=0.
  - FSM in IDLE, `tx`=1, `tx_busy`=0.
  - `data` high-Z unless `rd && io_sel`.
- **Write-to-line latency**
  - A byte pushed at edge N into an empty FIFO is popped at edge N+1.
  - `tx` falls and `tx_busy` rises after edge N+1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles with `tx_busy`=1.
- **Back-to-back frames:** exactly one IDLE cycle (`tx`=1, `tx_busy`=0) between consecutive frames.
- **Status/count reads:** reflect register state after the most recent edge, combinationally.
- **Reset mid-frame:** `rst` at any edge aborts the frame and flushes the FIFO; after that edge `tx`=1 and `tx_busy`=0.
- **Count range:** occupancy reaches `FIFO_DEPTH` and never exceeds it; pointer wrap-around is transparent to software.

## Test plan
- Reset, then read 5'h1F → `data`=8'h01, `tx`=1, `tx_busy`=0; read 5'h1E → 8'h00.
- `CLKS_PER_BIT`=4, write 8'hA5 to 5'h1E → `tx` low 4 cycles starting the cycle after the next edge, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; `tx_busy` high exactly 40 cycles.
- Six consecutive writes 8'h01..8'h06 to 5'h1E → 8'h01 is on the line; FIFO holds 02–05; 8'h06 is dropped; status reads 8'h0E; wire order is 01,02,03,04,05 with one idle cycle between frames.
- With overflow set, write 8'h08 to 5'h1F → status reads 8'h06 while still full and busy; write 8'h00 to 5'h1F does not clear overflow.
- `rd`=1 with `addr`=5'h03 → `io_sel`=0 and `data` is high-Z; `wr`=1 at 5'h03 leaves count and FIFO unchanged.
- Assert `rst` for one edge mid-DATA with 3 bytes queued → after that edge `tx`=1, `tx_busy`=0, status 8'h01, and no further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the VeriRISC bus: byte FIFO on TXDATA_ADDR, status on STATUS_ADDR.
// State | meaning: IDLE line high, waiting for FIFO data | START start bit | DATA 8 data bits LSB first | STOP stop bit
module mmio_uart_tx #(
  parameter int                AWIDTH       = 5,
  parameter int                DWIDTH       = 8,
  parameter logic [AWIDTH-1:0] TXDATA_ADDR  = 5'h1E,
  parameter logic [AWIDTH-1:0] STATUS_ADDR  = 5'h1F,
  parameter int                FIFO_DEPTH   = 4,
  parameter int                CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  inout  wire  [DWIDTH-1:0] data,
  output logic              io_sel,
  output logic              tx,
  output logic              tx_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [DWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DWIDTH-1:0] shift_q;
  logic [TMR_W-1:0]  bit_tmr;
  logic [2:0]        bit_idx;

  logic sel_tx, sel_st, empty, full, push, pop, tmr_done;
  logic [DWIDTH-1:0] rd_data;

  assign sel_tx   = (addr == TXDATA_ADDR);
  assign sel_st   = (addr == STATUS_ADDR);
  assign io_sel   = sel_tx | sel_st;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign push     = wr && sel_tx && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign tmr_done = (bit_tmr == TMR_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data;
  end

  // A write to a full FIFO is dropped even if the serialiser pops on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr && sel_tx && full)
        overflow <= 1'b1;
      else if (wr && sel_st && data[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_START;
      S_START: if (tmr_done) state_d = S_DATA;
      S_DATA:  if (tmr_done && bit_idx == 3'd7) state_d = S_STOP;
      S_STOP:  if (tmr_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bit_tmr <= '0;
      bit_idx <= '0;
    end else if (state_q == S_IDLE) begin
      bit_tmr <= '0;
      bit_idx <= '0;
      if (pop) shift_q <= fifo_mem[rd_ptr];
    end else begin
      bit_tmr <= tmr_done ? '0 : bit_tmr + TMR_W'(1);
      if (state_q == S_DATA && tmr_done) begin
        shift_q <= shift_q >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = 1'b1;
    case (state_q)
      S_IDLE:  tx_busy = 1'b0;
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      S_STOP:  tx = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (sel_tx)
      rd_data = {{(DWIDTH - CNT_W){1'b0}}, count};
    else if (sel_st)
      rd_data = {{(DWIDTH - 4){1'b0}}, overflow, tx_busy, full, empty};
  end

  assign data = (rd && io_sel) ? rd_data : {DWIDTH{1'bz}};

endmodule
